// File: rtl/cv32e40p_irq_ctrl.sv
// Interrupt source aggregator feeding the core's irq_i vector.
// Fast lines are synchronised and latched per source as edge- or level-triggered,
// a machine timer (mtime/mtimecmp) raises irq 7, MSIP raises irq 3 and the
// external line raises irq 11. A small register port configures everything.
module cv32e40p_irq_ctrl #(
  parameter int unsigned NUM_FAST = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_FAST-1:0] fast_irq_i,
  input  logic                ext_irq_i,
  output logic [31:0]         irq_o,
  input  logic                irq_ack_i,
  input  logic [4:0]          irq_id_i,
  input  logic                reg_req_i,
  input  logic                reg_we_i,
  input  logic [4:0]          reg_addr_i,
  input  logic [31:0]         reg_wdata_i,
  output logic [31:0]         reg_rdata_o,
  output logic                reg_valid_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [2:0] W_MSIP     = 3'd0;
  localparam logic [2:0] W_PEND     = 3'd1;
  localparam logic [2:0] W_EDGE     = 3'd2;
  localparam logic [2:0] W_ENABLE   = 3'd3;
  localparam logic [2:0] W_MTIME_LO = 3'd4;
  localparam logic [2:0] W_MTIME_HI = 3'd5;
  localparam logic [2:0] W_CMP_LO   = 3'd6;
  localparam logic [2:0] W_CMP_HI   = 3'd7;

  // Synchroniser stages; s3 holds the previous s2 value for edge detection
  logic [NUM_FAST-1:0] fast_s1_q, fast_s2_q, fast_s3_q;
  logic                ext_s1_q, ext_s2_q;

  logic [NUM_FAST-1:0] pend_q, pend_d;
  logic [NUM_FAST-1:0] edge_q, edge_d;
  logic [NUM_FAST-1:0] enable_q, enable_d;
  logic                msip_q, msip_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         mtimecmp_q, mtimecmp_d;
  logic                mtip_q, mtip_d;
  logic [31:0]         irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                valid_q;

  logic [2:0]          word_s;
  logic                wr_s, rd_s, tick_s;
  logic [NUM_FAST-1:0] wdata_src_s;
  logic [NUM_FAST-1:0] ack_clr_s, w1c_s, to_edge_s, clr_s, rise_s;
  logic                unused_addr_s;

  assign word_s        = reg_addr_i[4:2];
  assign wr_s          = reg_req_i & reg_we_i;
  assign rd_s          = reg_req_i & ~reg_we_i;
  assign wdata_src_s   = reg_wdata_i[NUM_FAST-1:0];
  assign unused_addr_s = ^reg_addr_i[1:0];

  assign irq_o       = irq_q;
  assign reg_rdata_o = rdata_q;
  assign reg_valid_o = valid_q;

  // Configuration registers: MSIP, EDGE, ENABLE and MTIMECMP halves
  always_comb begin
    msip_d     = msip_q;
    edge_d     = edge_q;
    enable_d   = enable_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_s) begin
      case (word_s)
        W_MSIP:   msip_d     = reg_wdata_i[0];
        W_EDGE:   edge_d     = wdata_src_s;
        W_ENABLE: enable_d   = wdata_src_s;
        W_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], reg_wdata_i};
        W_CMP_HI: mtimecmp_d = {reg_wdata_i, mtimecmp_q[31:0]};
        default:  msip_d     = msip_q;
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Pending bits: edge sources latch rising edges (set beats clear), level sources follow s2
  always_comb begin
    for (int k = 0; k < NUM_FAST; k++) begin
      ack_clr_s[k] = irq_ack_i & (irq_id_i == 5'(16 + k));
    end
    if (wr_s && (word_s == W_PEND)) begin
      w1c_s = wdata_src_s & edge_q;
    end else begin
      w1c_s = '0;
    end
    if (wr_s && (word_s == W_EDGE)) begin
      to_edge_s = wdata_src_s & ~edge_q;
    end else begin
      to_edge_s = '0;
    end
    clr_s  = ack_clr_s | w1c_s | to_edge_s;
    rise_s = fast_s2_q & ~fast_s3_q;
    pend_d = (edge_d & (rise_s | (pend_q & ~clr_s))) | (~edge_d & fast_s2_q);
  end

  // Timer: prescaled mtime increment, register writes override the increment
  always_comb begin
    tick_s = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (wr_s && (word_s == W_MTIME_LO)) begin
      mtime_d = {mtime_q[63:32], reg_wdata_i};
    end else if (wr_s && (word_s == W_MTIME_HI)) begin
      mtime_d = {reg_wdata_i, mtime_q[31:0]};
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
    mtip_d = (mtime_d >= mtimecmp_d);
  end

  // Read data mux; data is zero whenever no read is being answered
  always_comb begin
    rdata_d = 32'h0;
    if (rd_s) begin
      case (word_s)
        W_MSIP:     rdata_d = {31'h0, msip_q};
        W_PEND:     rdata_d = 32'(pend_q);
        W_EDGE:     rdata_d = 32'(edge_q);
        W_ENABLE:   rdata_d = 32'(enable_q);
        W_MTIME_LO: rdata_d = mtime_q[31:0];
        W_MTIME_HI: rdata_d = mtime_q[63:32];
        W_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        W_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        default:    rdata_d = 32'h0;
      endcase
    end else begin
      rdata_d = 32'h0;
    end
  end

  // Interrupt vector composition from post-edge state; timer bit uses the registered mtip
  always_comb begin
    irq_d                   = 32'h0;
    irq_d[3]                = msip_d;
    irq_d[7]                = mtip_q;
    irq_d[11]               = ext_s2_q;
    irq_d[16 +: NUM_FAST]   = pend_d & enable_d;
  end

  // Two-flop synchronisers plus the delayed copy used for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fast_s1_q <= '0;
      fast_s2_q <= '0;
      fast_s3_q <= '0;
      ext_s1_q  <= 1'b0;
      ext_s2_q  <= 1'b0;
    end else begin
      fast_s1_q <= fast_irq_i;
      fast_s2_q <= fast_s1_q;
      fast_s3_q <= fast_s2_q;
      ext_s1_q  <= ext_irq_i;
      ext_s2_q  <= ext_s1_q;
    end
  end

  // Architectural state, timer and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      edge_q     <= '0;
      enable_q   <= '0;
      msip_q     <= 1'b0;
      presc_q    <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_q     <= 1'b0;
      irq_q      <= 32'h0;
      rdata_q    <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      edge_q     <= edge_d;
      enable_q   <= enable_d;
      msip_q     <= msip_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= mtip_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      valid_q    <= reg_req_i;
    end
  end

endmodule

// File: tb/tb_cv32e40p_irq_ctrl.sv
// Self-checking bench for cv32e40p_irq_ctrl. Register responses go through a
// scoreboard queue; interrupt vector expectations are checked inline per scenario.
module tb_cv32e40p_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] fast_irq_i;
  logic        ext_irq_i;
  logic [31:0] irq_o;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_valid_o;

  int vectors     = 0;
  int miscompares = 0;
  int ecnt        = 0;

  typedef struct packed {
    logic        rd;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  cv32e40p_irq_ctrl #(.NUM_FAST(16), .PRESCALE(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .fast_irq_i  (fast_irq_i),
    .ext_irq_i   (ext_irq_i),
    .irq_o       (irq_o),
    .irq_ack_i   (irq_ack_i),
    .irq_id_i    (irq_id_i),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_valid_o (reg_valid_o)
  );

  always #5 clk = ~clk;

  // Advance one edge, sample 1 time unit later and retire any register response
  task automatic cyc();
    sb_t ent;
    @(posedge clk);
    #1;
    ecnt++;
    if (reg_valid_o === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_valid: valid=1 with no outstanding access");
      end else begin
        ent = sb_q.pop_front();
        if (ent.rd && (reg_rdata_o !== ent.exp)) begin
          miscompares++;
          $display("FAIL reg_read: rdata=%h expected %h", reg_rdata_o, ent.exp);
        end
      end
    end else begin
      vectors++;
      if (reg_rdata_o !== 32'h0 || sb_q.size() != 0) begin
        miscompares++;
        $display("FAIL idle_port: rdata=%h outstanding=%0d expected rdata 0 and none outstanding",
                 reg_rdata_o, sb_q.size());
        sb_q.delete();
      end
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sb_t ent;
    ent.rd = 1'b0;
    ent.exp = 32'h0;
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    sb_q.push_back(ent);
    cyc();
    reg_req_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    sb_t ent;
    ent.rd = 1'b1;
    ent.exp = e;
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a; reg_wdata_i = 32'h0;
    sb_q.push_back(ent);
    cyc();
    reg_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; fast_irq_i = 16'hFFFF; ext_irq_i = 1'b0;
    irq_ack_i = 1'b0; irq_id_i = 5'd0;
    reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = 5'd0; reg_wdata_i = 32'h0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vectors++;
      if (irq_o !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_irq: irq_o=%h expected %h", irq_o, 32'h0);
      end
    end
    rst_i = 1'b0; ecnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (irq_o !== 32'h0) begin
        miscompares++;
        $display("FAIL post_reset_irq: irq_o=%h expected %h", irq_o, 32'h0);
      end
    end
    rd(5'h18, 32'hFFFF_FFFF);
    rd(5'h1C, 32'hFFFF_FFFF);
    fast_irq_i = 16'h0000;
  endtask

  task automatic test_fast_edge();
    logic [31:0] exp_v;
    wr(5'h08, 32'h0000_0005);
    wr(5'h0C, 32'h0000_FFFF);
    repeat (4) cyc();
    vectors++;
    if (irq_o !== 32'h0) begin
      miscompares++;
      $display("FAIL edge_idle: irq_o=%h expected %h", irq_o, 32'h0);
    end
    fast_irq_i[2] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      fast_irq_i[2] = 1'b0;
      exp_v = (e >= 3) ? 32'h0004_0000 : 32'h0;
      vectors++;
      if (irq_o !== exp_v) begin
        miscompares++;
        $display("FAIL edge_latency e%0d: irq_o=%h expected %h", e, irq_o, exp_v);
      end
    end
    irq_ack_i = 1'b1; irq_id_i = 5'd19;
    cyc();
    irq_id_i = 5'd2;
    vectors++;
    if (irq_o !== 32'h0004_0000) begin
      miscompares++;
      $display("FAIL ack_other_id19: irq_o=%h expected %h", irq_o, 32'h0004_0000);
    end
    cyc();
    irq_id_i = 5'd18;
    vectors++;
    if (irq_o !== 32'h0004_0000) begin
      miscompares++;
      $display("FAIL ack_other_id2: irq_o=%h expected %h", irq_o, 32'h0004_0000);
    end
    cyc();
    irq_ack_i = 1'b0;
    vectors++;
    if (irq_o !== 32'h0) begin
      miscompares++;
      $display("FAIL ack_clear: irq_o=%h expected %h", irq_o, 32'h0);
    end
  endtask

  task automatic test_same_cycle();
    fast_irq_i[0] = 1'b1;
    cyc();
    fast_irq_i[0] = 1'b0;
    cyc(); cyc();
    vectors++;
    if (irq_o !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL src0_set: irq_o=%h expected %h", irq_o, 32'h0001_0000);
    end
    cyc(); cyc();
    fast_irq_i[0] = 1'b1;
    cyc();
    fast_irq_i[0] = 1'b0;
    cyc();
    irq_ack_i = 1'b1; irq_id_i = 5'd16;
    cyc();
    irq_ack_i = 1'b0;
    vectors++;
    if (irq_o !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL set_beats_ack: irq_o=%h expected %h", irq_o, 32'h0001_0000);
    end
    rd(5'h04, 32'h0000_0001);
    wr(5'h04, 32'h0000_0001);
    vectors++;
    if (irq_o !== 32'h0) begin
      miscompares++;
      $display("FAIL w1c_clear: irq_o=%h expected %h", irq_o, 32'h0);
    end
    rd(5'h04, 32'h0);
  endtask

  task automatic test_level();
    logic [31:0] exp_v;
    fast_irq_i[5] = 1'b1; ext_irq_i = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cyc();
      exp_v = (e >= 3) ? 32'h0020_0800 : 32'h0;
      vectors++;
      if (irq_o !== exp_v) begin
        miscompares++;
        $display("FAIL level_rise e%0d: irq_o=%h expected %h", e, irq_o, exp_v);
      end
    end
    irq_ack_i = 1'b1; irq_id_i = 5'd21;
    cyc();
    irq_ack_i = 1'b0;
    vectors++;
    if (irq_o !== 32'h0020_0800) begin
      miscompares++;
      $display("FAIL level_ack_ignored: irq_o=%h expected %h", irq_o, 32'h0020_0800);
    end
    wr(5'h04, 32'h0000_0020);
    vectors++;
    if (irq_o !== 32'h0020_0800) begin
      miscompares++;
      $display("FAIL level_w1c_ignored: irq_o=%h expected %h", irq_o, 32'h0020_0800);
    end
    wr(5'h0C, 32'h0000_FFDF);
    vectors++;
    if (irq_o !== 32'h0000_0800) begin
      miscompares++;
      $display("FAIL enable_mask: irq_o=%h expected %h", irq_o, 32'h0000_0800);
    end
    wr(5'h0C, 32'h0000_FFFF);
    fast_irq_i[5] = 1'b0; ext_irq_i = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      cyc();
      exp_v = (e >= 3) ? 32'h0 : 32'h0020_0800;
      vectors++;
      if (irq_o !== exp_v) begin
        miscompares++;
        $display("FAIL level_fall e%0d: irq_o=%h expected %h", e, irq_o, exp_v);
      end
    end
  endtask

  task automatic test_msip();
    wr(5'h00, 32'h0000_0001);
    vectors++;
    if (irq_o !== 32'h0000_0008) begin
      miscompares++;
      $display("FAIL msip_set: irq_o=%h expected %h", irq_o, 32'h0000_0008);
    end
    rd(5'h00, 32'h0000_0001);
    wr(5'h00, 32'hFFFF_FFFE);
    vectors++;
    if (irq_o !== 32'h0) begin
      miscompares++;
      $display("FAIL msip_clear: irq_o=%h expected %h", irq_o, 32'h0);
    end
    rd(5'h00, 32'h0);
    wr(5'h00, 32'h0000_0003);
    rd(5'h00, 32'h0000_0001);
    wr(5'h00, 32'h0);
  endtask

  task automatic test_back_to_back();
    wr(5'h08, 32'hFFFF_FFFF);
    rd(5'h0B, 32'h0000_FFFF);
    wr(5'h0C, 32'h0000_1234);
    rd(5'h0C, 32'h0000_1234);
    rd(5'h0D, 32'h0000_1234);
    rd(5'h04, 32'h0);
  endtask

  task automatic test_timer();
    logic exp_b;
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0; ecnt = 0;
    wr(5'h1C, 32'h0);
    wr(5'h18, 32'h3);
    while (ecnt < 13) begin
      cyc();
      exp_b = (ecnt >= 13);
      vectors++;
      if (irq_o[7] !== exp_b) begin
        miscompares++;
        $display("FAIL mtip_rise edge%0d: irq_o[7]=%b expected %b", ecnt, irq_o[7], exp_b);
      end
    end
    rd(5'h10, 32'h3);
    wr(5'h18, 32'd100);
    cyc();
    vectors++;
    if (irq_o[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL mtip_clear: irq_o[7]=%b expected %b", irq_o[7], 1'b0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8 && (ecnt % 4) != 1; i++) cyc();
    wr(5'h10, 32'hFFFF_FFFF);
    wr(5'h14, 32'hFFFF_FFFF);
    rd(5'h10, 32'hFFFF_FFFF);
    rd(5'h10, 32'h0);
    rd(5'h14, 32'h0);
    for (int i = 0; i < 8 && (ecnt % 4) != 3; i++) cyc();
    wr(5'h10, 32'h0000_1234);
    rd(5'h10, 32'h0000_1234);
    for (int i = 0; i < 8 && (ecnt % 4) != 0; i++) cyc();
    rd(5'h10, 32'h0000_1235);
  endtask

  task automatic test_reset_mid();
    wr(5'h08, 32'h0000_0004);
    wr(5'h0C, 32'h0000_0004);
    wr(5'h00, 32'h0000_0001);
    fast_irq_i[2] = 1'b1;
    cyc();
    fast_irq_i[2] = 1'b0;
    cyc(); cyc();
    vectors++;
    if (irq_o !== 32'h0004_0088) begin
      miscompares++;
      $display("FAIL pre_reset_state: irq_o=%h expected %h", irq_o, 32'h0004_0088);
    end
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0; ecnt = 0;
    vectors++;
    if (irq_o !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_irq: irq_o=%h expected %h", irq_o, 32'h0);
    end
    rd(5'h10, 32'h0);
    rd(5'h08, 32'h0);
    rd(5'h18, 32'hFFFF_FFFF);
    rd(5'h00, 32'h0);
    vectors++;
    if (irq_o !== 32'h0) begin
      miscompares++;
      $display("FAIL after_reset_irq: irq_o=%h expected %h", irq_o, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_fast_edge();
    test_same_cycle();
    test_level();
    test_msip();
    test_back_to_back();
    test_timer();
    test_wrap();
    test_reset_mid();
    cyc();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: outstanding=%0d expected %0d", sb_q.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
